// File: rtl/calc_display_driver_pkg.sv
// Shared types and constants for the calculator display path.
// Digit codes, status encoding and the non-numeric segment patterns live here.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_ERR  = 2'b10,
      ST_RSVD = 2'b11
   } status_t;

   localparam int unsigned NUM_DIGITS_DEF = 8;

   localparam logic [3:0] DIG_MAX   = 4'h9;
   localparam logic [3:0] DIG_MINUS = 4'hA;
   localparam logic [3:0] DIG_BLANK = 4'hF;

   // gfedcba, active-low
   localparam logic [6:0] SEG_E    = 7'h06;
   localparam logic [6:0] SEG_R    = 7'h2F;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // A code holds a visible symbol that must not be blanked away as a leading zero.
   function automatic logic is_significant(input logic [3:0] code);
      return (code != 4'h0) && (code <= DIG_MINUS);
   endfunction

endpackage

// File: rtl/calc_display_driver_if.sv
// Digit stream from the calculator core plus the multiplexed display pins.
// master = core/board side, slave = display driver.
interface calc_display_driver_if
   import calc_pkg::*;
#(
   parameter int NUM_DIGITS = 8
);
   logic                  wr_en;
   logic [3:0]            digit_in;
   logic [2:0]            pos_in;
   logic                  clr;
   status_t               status_in;
   logic [6:0]            seg_n;
   logic                  dp_n;
   logic [NUM_DIGITS-1:0] an_n;

   modport master (
      output wr_en, digit_in, pos_in, clr, status_in,
      input  seg_n, dp_n, an_n
   );

   modport slave (
      input  wr_en, digit_in, pos_in, clr, status_in,
      output seg_n, dp_n, an_n
   );
endinterface

// File: rtl/calc_display_driver_seg7_decode.sv
// Digit code to active-low gfedcba segment pattern; codes B-F render blank.
module seg7_decode
   import calc_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_OFF;
      case (code)
         4'h0:      seg = 7'h40;
         4'h1:      seg = 7'h79;
         4'h2:      seg = 7'h24;
         4'h3:      seg = 7'h30;
         4'h4:      seg = 7'h19;
         4'h5:      seg = 7'h12;
         4'h6:      seg = 7'h02;
         4'h7:      seg = 7'h78;
         4'h8:      seg = 7'h00;
         4'h9:      seg = 7'h10;
         DIG_MINUS: seg = SEG_DASH;
         default:   seg = SEG_OFF;
      endcase
   end
endmodule

// File: rtl/calc_display_driver.sv
// Captures the core's digit stream into an 8-entry buffer and scans it onto
// common-anode 7-segment displays with leading-zero blanking and an "Err" override.
module calc_display_driver
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int NUM_DIGITS  = 8
)(
   input  logic                 clock,
   input  logic                 reset,
   calc_display_driver_if.slave bus
);
   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [NUM_DIGITS-1:0][3:0] dbuf_q;
   logic [CNT_W-1:0]           pre_q;
   logic                       tick;
   logic [2:0]                 idx_q;
   logic [2:0]                 msd;
   logic [3:0]                 sel_code;
   logic [6:0]                 dec_seg;
   logic [6:0]                 seg_d, seg_q;
   logic [NUM_DIGITS-1:0]      an_d, an_q, an_sel;
   logic                       err;

   // Display buffer; clear wins over a same-cycle write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         dbuf_q <= '0;
      else if (bus.clr)
         dbuf_q <= '0;
      else if (bus.wr_en)
         dbuf_q[bus.pos_in] <= bus.digit_in;
   end

   assign tick = (pre_q == CNT_W'(REFRESH_DIV - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pre_q <= '0;
      else if (tick)
         pre_q <= '0;
      else
         pre_q <= pre_q + 1'b1;
   end

   // idx_q names the slot loaded at the coming tick, so slot 0 is first after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         idx_q <= '0;
      else if (tick)
         idx_q <= idx_q + 3'd1;
   end

   always_comb begin
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++)
         if (is_significant(dbuf_q[i]))
            msd = 3'(i);
   end

   assign sel_code = dbuf_q[idx_q];
   assign an_sel   = ~(NUM_DIGITS'(1) << idx_q);
   assign err      = (bus.status_in == ST_ERR);

   seg7_decode u_dec (
      .code (sel_code),
      .seg  (dec_seg)
   );

   always_comb begin
      seg_d = SEG_OFF;
      an_d  = '1;
      if (err) begin
         if (idx_q == 3'd2) begin
            seg_d = SEG_E;
            an_d  = an_sel;
         end else if (idx_q < 3'd2) begin
            seg_d = SEG_R;
            an_d  = an_sel;
         end
      end else if (idx_q <= msd) begin
         seg_d = dec_seg;
         an_d  = an_sel;
      end
   end

   // Registered pins so the anode/segment pair changes together, glitch-free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_q <= SEG_OFF;
         an_q  <= '1;
      end else if (tick) begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign bus.seg_n = seg_q;
   assign bus.an_n  = an_q;
   assign bus.dp_n  = 1'b1;

endmodule

// File: tb/tb_calc_display_driver.sv
// Randomized bench for calc_display_driver with a slot-level reference model
// and a few literal display checks for the directed scenarios.
module tb_calc_display_driver;
   import calc_pkg::*;

   localparam int DIV = 4;

   localparam logic [6:0] SEG_TBL [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h10 ^ 7'h10, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   logic clock = 1'b0;
   logic reset = 1'b1;

   calc_display_driver_if #(.NUM_DIGITS(8)) bus ();

   calc_display_driver #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a tick every DIV cycles after reset, slots visited 0,1,..,7,0.
   logic [3:0] m_buf [8];
   int         m_cyc;
   int         m_ntick;
   int         m_last_slot;
   logic [7:0] exp_an;
   logic [6:0] exp_seg;

   function automatic logic [14:0] exp_out(input int s, input logic [3:0] b [8], input logic is_err);
      int msd;
      logic [7:0] an1;
      msd = 0;
      an1 = ~(8'd1 << s);
      for (int i = 1; i < 8; i++)
         if (b[i] != 4'h0 && b[i] <= 4'hA) msd = i;
      if (is_err) begin
         if (s == 2) return {an1, 7'h06};
         if (s < 2)  return {an1, 7'h2F};
         return {8'hFF, 7'h7F};
      end
      if (s > msd) return {8'hFF, 7'h7F};
      return {an1, SEG_TBL[b[s]]};
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) m_buf[i] <= 4'h0;
         m_cyc       <= 0;
         m_ntick     <= 0;
         m_last_slot <= 0;
         exp_an      <= 8'hFF;
         exp_seg     <= 7'h7F;
      end else begin
         m_cyc <= m_cyc + 1;
         if ((m_cyc + 1) % DIV == 0) begin
            {exp_an, exp_seg} <= exp_out(m_ntick % 8, m_buf, bus.status_in == ST_ERR);
            m_last_slot <= m_ntick % 8;
            m_ntick     <= m_ntick + 1;
         end
         if (bus.clr)
            for (int i = 0; i < 8; i++) m_buf[i] <= 4'h0;
         else if (bus.wr_en)
            m_buf[bus.pos_in] <= bus.digit_in;
      end
   end

   always @(negedge clock) begin
      chk("an_n", {24'd0, bus.an_n}, {24'd0, exp_an});
      chk("seg_n", {25'd0, bus.seg_n}, {25'd0, exp_seg});
      chk("dp_n", {31'd0, bus.dp_n}, 32'd1);
   end

   // Wait for a fresh tick that shows slot s, then compare against literals.
   task automatic check_slot(input int s, input logic [7:0] an, input logic [6:0] seg, input string name);
      int start;
      bit ok;
      start = m_ntick;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (m_ntick > start && m_last_slot == s) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL %s: timeout waiting for slot %0d", name, s);
      end else begin
         chk({name, "_an"}, {24'd0, bus.an_n}, {24'd0, an});
         chk({name, "_seg"}, {25'd0, bus.seg_n}, {25'd0, seg});
      end
   endtask

   task automatic write_digit(input logic [2:0] p, input logic [3:0] d);
      @(negedge clock);
      bus.wr_en    = 1'b1;
      bus.pos_in   = p;
      bus.digit_in = d;
      @(negedge clock);
      bus.wr_en    = 1'b0;
   endtask

   initial begin
      bit ok;
      bus.wr_en     = 1'b0;
      bus.clr       = 1'b0;
      bus.pos_in    = 3'd0;
      bus.digit_in  = 4'h0;
      bus.status_in = ST_IDLE;

      repeat (3) @(negedge clock);
      chk("rst_an", {24'd0, bus.an_n}, 32'hFF);
      chk("rst_seg", {25'd0, bus.seg_n}, 32'h7F);
      reset = 1'b0;
      for (int i = 0; i < DIV - 1; i++) begin
         @(negedge clock);
         chk("pre_tick_an", {24'd0, bus.an_n}, 32'hFF);
      end
      check_slot(0, 8'hFE, 7'h40, "empty_s0");
      check_slot(1, 8'hFF, 7'h7F, "empty_s1");

      write_digit(3'd0, 4'h7);
      write_digit(3'd1, 4'h2);
      write_digit(3'd2, 4'h1);
      check_slot(0, 8'hFE, 7'h78, "lzb_s0");
      check_slot(1, 8'hFD, 7'h24, "lzb_s1");
      check_slot(2, 8'hFB, 7'h79, "lzb_s2");
      check_slot(3, 8'hFF, 7'h7F, "lzb_s3");
      check_slot(7, 8'hFF, 7'h7F, "lzb_s7");

      write_digit(3'd3, 4'hA);
      check_slot(3, 8'hF7, 7'h3F, "minus_s3");
      check_slot(4, 8'hFF, 7'h7F, "minus_s4");

      write_digit(3'd0, 4'h3);
      @(negedge clock);
      bus.status_in = ST_ERR;
      check_slot(2, 8'hFB, 7'h06, "err_s2");
      check_slot(3, 8'hFF, 7'h7F, "err_s3");
      check_slot(0, 8'hFE, 7'h2F, "err_s0");
      check_slot(1, 8'hFD, 7'h2F, "err_s1");
      bus.status_in = ST_IDLE;
      check_slot(2, 8'hFB, 7'h79, "resume_s2");
      check_slot(3, 8'hF7, 7'h3F, "resume_s3");
      check_slot(0, 8'hFE, 7'h30, "resume_s0");

      bus.status_in = ST_BUSY;
      write_digit(3'd1, 4'h9);
      check_slot(1, 8'hFD, 7'h10, "busy_s1");
      bus.status_in = ST_IDLE;

      @(negedge clock);
      bus.clr      = 1'b1;
      bus.wr_en    = 1'b1;
      bus.pos_in   = 3'd0;
      bus.digit_in = 4'h5;
      @(negedge clock);
      bus.clr   = 1'b0;
      bus.wr_en = 1'b0;
      check_slot(0, 8'hFE, 7'h40, "clr_s0");
      check_slot(3, 8'hFF, 7'h7F, "clr_s3");

      write_digit(3'd5, 4'h8);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (m_ntick > 0 && m_last_slot == 5) begin
            ok = 1'b1;
            break;
         end
      end
      chk("midscan_reached", {31'd0, ok}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_an", {24'd0, bus.an_n}, 32'hFF);
      chk("async_rst_seg", {25'd0, bus.seg_n}, 32'h7F);
      @(negedge clock);
      reset = 1'b0;
      check_slot(0, 8'hFE, 7'h40, "post_rst_s0");
      check_slot(5, 8'hFF, 7'h7F, "post_rst_s5");

      for (int c = 0; c < 1500; c++) begin
         @(negedge clock);
         bus.wr_en     = ($urandom_range(0, 1) == 1);
         bus.pos_in    = 3'($urandom_range(0, 7));
         bus.digit_in  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         bus.clr       = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 15) == 0)
            bus.status_in = status_t'($urandom_range(0, 3));
      end
      @(negedge clock);
      bus.wr_en = 1'b0;
      bus.clr   = 1'b0;
      repeat (40) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
